mux_pipe: RTL and testbench
===========================

# mux_pipe

Parametrised N:1 select stage with a registered output and a valid/ready handshake. It generalises the datapath 2:1 multiplexers to NUM_INPUTS sources of WIDTH bits. A two-entry skid buffer sustains one transfer per cycle under backpressure. It sits between pipeline stages, for example forwarding and operand selection ahead of the ALU, where the consumer may stall.

## Interface
Parameters:
- WIDTH, 32, data width of each source and of the output.
- NUM_INPUTS, 4, number of sources; must be ≥2.
- SEL_W, derived, equal to max(1, $clog2(NUM_INPUTS)); localparam, not overridable.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  source beat present.
- in_ready  out  1  block can accept a beat this cycle.
- sel  in  SEL_W  source index, sampled on accept.
- din  in  NUM_INPUTS*WIDTH  flattened sources; source i is din[i*WIDTH +: WIDTH].
- out_valid  out  1  dout holds a beat.
- out_ready  in  1  consumer takes the beat this cycle.
- dout  out  WIDTH  selected data, registered.
- sel_err  out  1  sideband for the current output beat; 1 means sel was ≥ NUM_INPUTS.

## Operation
- Accept occurs when in_valid && in_ready.
- On accept, the captured value depends on sel:
  - sel < NUM_INPUTS: captured value is din[sel*WIDTH +: WIDTH], with err = 0.
  - sel ≥ NUM_INPUTS (non-power-of-two NUM_INPUTS only): captured value is 0, with err = 1. An X-free output is required.
- Storage:
  - Main register (M) drives dout, sel_err and out_valid.
  - Skid register (S) holds an overflow beat.
- Drain occurs when out_valid && out_ready.
- Per-cycle update rules:
  - M empty, or M draining with S empty: an accepted beat loads M.
  - M full, not draining, S empty: an accepted beat loads S.
  - M draining, S full: S moves to M and S becomes empty. in_ready is 0 that cycle, so there is no simultaneous accept.
  - M draining, no accept, S empty: M becomes empty and out_valid goes to 0.
- in_ready = !S_full && !rst. It is a function of registered state only, with no combinational path from out_ready.
- Ordering is strictly FIFO. No beat is duplicated or dropped.
- Holding contract: while out_valid=1 and out_ready=0, dout and sel_err stay stable.
- Behaviour when in_valid is deasserted before accept is don't-care for the block; it never samples din or sel without an accept.

## Timing
- Reset (rst high at an edge):
  - out_valid=0, dout=0, sel_err=0, S empty.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst falls.
- Reset mid-operation discards both M and S. The next cycle shows the reset values above.
- Latency: a beat accepted at edge k is visible on dout, with out_valid=1, after edge k, i.e. 1 cycle.
- Throughput: 1 beat/cycle with out_ready held high. in_ready stays 1 throughout.
- Backpressure: out_ready=0 for ≥2 cycles with continuous input:
  - Accept 1 fills M.
  - Accept 2 fills S.
  - in_ready=0 from the next cycle.
- Release: the first drain cycle moves S→M. in_ready returns to 1 the cycle after.
- Simultaneous accept and drain with S empty: M takes the new beat and out_valid stays 1.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 → out_valid=0, dout=0, sel_err=0, in_ready=0 during reset; in_ready=1 afterwards; no beat captured.
- Streaming (WIDTH=32, NUM_INPUTS=4):
  - Stimulus: din sources 0..3 = 32'h00000001, 32'h0000FFFF, 32'hDEADBEEF, 32'h80000000; sel 0,1,2,3 on consecutive cycles; out_ready=1.
  - Required: dout 00000001, 0000FFFF, DEADBEEF, 80000000 on consecutive cycles, each 1 cycle after its accept; in_ready never drops.
- Backpressure:
  - Stimulus: out_ready=0, push sel=1, 2, 3.
  - Required: two beats accepted, in_ready=0; the third is held upstream.
  - Stimulus: out_ready=1.
  - Required: output sequence 0000FFFF, DEADBEEF, 80000000 with no loss; dout stable while stalled.
- Out-of-range select (NUM_INPUTS=3, SEL_W=2):
  - Stimulus: sel=3.
  - Required: dout=0, sel_err=1 for that beat; a following sel=0 beat gives sel_err=0 and source-0 data.
- Mid-operation reset: with M and S both full and out_ready=0, pulse rst for 1 cycle → out_valid=0 and in_ready=1 the cycle after rst falls; stale beats never appear.
- Narrow instance (WIDTH=5, NUM_INPUTS=2):
  - Stimulus: sources 5'b00001 and 5'b11111; sel=0, then sel=1.
  - Required: dout=00001, then 11111; never X.

Source files
------------

// File: rtl/mux_pipe.sv
// N:1 select stage with a registered output and a two-entry skid buffer.
// Source selection is one-hot AND-OR, so an out-of-range select yields zero data with no X.
module mux_pipe #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  localparam int SEL_W     = ($clog2(NUM_INPUTS) < 1) ? 1 : $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_INPUTS*WIDTH-1:0] din,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            dout,
  output logic                        sel_err
);

  logic [NUM_INPUTS-1:0] hit;
  logic [WIDTH-1:0]      masked [NUM_INPUTS];
  logic [WIDTH-1:0]      cap_data;
  logic                  cap_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_src
      assign hit[gi]    = (sel == SEL_W'(gi));
      assign masked[gi] = hit[gi] ? din[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cap_data = cap_data | masked[i];
    end
    cap_err = ~|hit;
  end

  logic             m_valid_reg;
  logic [WIDTH-1:0] m_data_reg;
  logic             m_err_reg;
  logic             s_valid_reg;
  logic [WIDTH-1:0] s_data_reg;
  logic             s_err_reg;
  logic             accept;
  logic             drain;

  // Ready depends only on skid occupancy, never on out_ready.
  assign in_ready = !s_valid_reg && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = m_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      m_err_reg   <= 1'b0;
      s_valid_reg <= 1'b0;
      s_data_reg  <= '0;
      s_err_reg   <= 1'b0;
    end else if (s_valid_reg) begin
      // Skid full: no accept possible, so only a drain can move S forward.
      if (drain) begin
        m_data_reg  <= s_data_reg;
        m_err_reg   <= s_err_reg;
        s_valid_reg <= 1'b0;
      end
    end else if (!m_valid_reg || drain) begin
      if (accept) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= cap_data;
        m_err_reg   <= cap_err;
      end else if (drain) begin
        m_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      s_valid_reg <= 1'b1;
      s_data_reg  <= cap_data;
      s_err_reg   <= cap_err;
    end
  end

  assign out_valid = m_valid_reg;
  assign dout      = m_data_reg;
  assign sel_err   = m_err_reg;

endmodule

// File: tb/tb_mux_pipe.sv
// Scoreboard bench for mux_pipe: three instances (32x4, 32x3, 5x2) share one control stream.
// A FIFO-occupancy reference model predicts readiness, validity and the data of each beat.
module tb_mux_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [1:0]   sel;
  logic [127:0] din_a;
  logic [95:0]  din_b;
  logic [9:0]   din_c;

  logic        ready_a, ready_b, ready_c;
  logic        ov_a, ov_b, ov_c;
  logic [31:0] dout_a, dout_b;
  logic [4:0]  dout_c;
  logic        err_a, err_b, err_c;

  assign din_b = din_a[95:0];

  always #5 clk = ~clk;

  mux_pipe #(.WIDTH(32), .NUM_INPUTS(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a), .sel(sel),
    .din(din_a), .out_valid(ov_a), .out_ready(out_ready), .dout(dout_a), .sel_err(err_a)
  );
  mux_pipe #(.WIDTH(32), .NUM_INPUTS(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b), .sel(sel),
    .din(din_b), .out_valid(ov_b), .out_ready(out_ready), .dout(dout_b), .sel_err(err_b)
  );
  mux_pipe #(.WIDTH(5), .NUM_INPUTS(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_c), .sel(sel[0:0]),
    .din(din_c), .out_valid(ov_c), .out_ready(out_ready), .dout(dout_c), .sel_err(err_c)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        eb;
    logic [4:0]  c;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rst_seen = 0;
  bit   post_rst = 0;
  bit   prev_stall = 0;
  logic [31:0] prev_dout_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t predict(input logic [1:0] s, input logic [127:0] da, input logic [9:0] dc);
    exp_t e;
    e.a = da[int'(s)*32 +: 32];
    if (s < 2'd3) begin
      e.b  = da[int'(s)*32 +: 32];
      e.eb = 1'b0;
    end else begin
      e.b  = 32'h0;
      e.eb = 1'b1;
    end
    e.c = dc[int'(s[0])*5 +: 5];
    return e;
  endfunction

  // Monitor: runs on the falling edge, checks outputs, then advances the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", {29'b0, ready_a, ready_b, ready_c}, 32'h0);
      q.delete();
      rst_seen   = 1;
      post_rst   = 1;
      prev_stall = 0;
    end else if (rst_seen) begin
      bit held, do_drain, do_accept;
      if (post_rst) begin
        chk("reset_dout_a", dout_a, 32'h0);
        chk("reset_dout_c", {27'b0, dout_c}, 32'h0);
        chk("reset_err", {29'b0, err_a, err_b, err_c}, 32'h0);
        post_rst = 0;
      end
      held = (q.size() > 0);
      chk("out_valid", {29'b0, ov_a, ov_b, ov_c}, held ? 32'h7 : 32'h0);
      chk("in_ready", {29'b0, ready_a, ready_b, ready_c}, (q.size() < 2) ? 32'h7 : 32'h0);
      if (prev_stall) chk("hold_dout_a", dout_a, prev_dout_a);
      if (held) begin
        chk("dout_a", dout_a, q[0].a);
        chk("dout_b", dout_b, q[0].b);
        chk("sel_err_b", {31'b0, err_b}, {31'b0, q[0].eb});
        chk("dout_c", {27'b0, dout_c}, {27'b0, q[0].c});
        chk("sel_err_ac", {30'b0, err_a, err_c}, 32'h0);
      end
      do_drain  = held && out_ready;
      do_accept = in_valid && (q.size() < 2);
      prev_stall  = held && !out_ready;
      prev_dout_a = dout_a;
      if (do_drain) void'(q.pop_front());
      if (do_accept) q.push_back(predict(sel, din_a, din_c));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    bit ok;
    in_valid = 1'b1;
    sel      = s;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ok = ready_a;
      step();
      if (ok) return;
    end
    n_err++;
    $display("FAIL send_timeout actual=no_accept required=accept sel=%0d", s);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    sel       = 2'd0;
    din_a     = {32'h80000000, 32'hDEADBEEF, 32'h0000FFFF, 32'h00000001};
    din_c     = {5'b11111, 5'b00001};
    step();
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    step();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) send(2'(s));
    in_valid = 1'b0;
    repeat (3) step();

    // Backpressure: two accepted, the third held upstream.
    out_ready = 1'b0;
    send(2'd1);
    send(2'd2);
    in_valid = 1'b1;
    sel      = 2'd3;
    repeat (3) step();
    out_ready = 1'b1;
    send(2'd3);
    in_valid = 1'b0;
    repeat (4) step();

    // Out-of-range select followed by an in-range one.
    send(2'd3);
    send(2'd0);
    in_valid = 1'b0;
    repeat (3) step();

    // Reset with both registers full and the consumer stalled.
    out_ready = 1'b0;
    send(2'd1);
    send(2'd2);
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();
    out_ready = 1'b1;
    repeat (2) step();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = 2'($urandom_range(0, 3));
      din_a     = {$urandom(), $urandom(), $urandom(), $urandom()};
      din_c     = 10'($urandom_range(0, 1023));
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("final_empty", q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
